// File: rtl/score_keeper.sv
// Game bookkeeping for a maze game: BCD score, lives, level, remaining dots and game-phase FSM.
// All outputs registered; one vga_pix_clk from strobe to response. No backpressure; strobes are sampled every cycle.
module score_keeper #(
    parameter int CANDY_TOTAL  = 244,
    parameter int START_LIVES  = 3,
    parameter int DEATH_FRAMES = 120,
    parameter int CLEAR_FRAMES = 180
) (
    input  logic        vga_pix_clk,
    input  logic        rst_n,
    input  logic        frame_stb,
    input  logic        start_btn,
    input  logic        ate_candy_stb,
    input  logic        ate_power_cookie_stb,
    input  logic        pac_hit_stb,
    output logic [19:0] score_bcd,
    output logic [2:0]  lives,
    output logic [3:0]  level,
    output logic [7:0]  dots_left,
    output logic [2:0]  game_state,
    output logic        play_en,
    output logic        respawn_stb,
    output logic        map_reload_stb
);
    localparam int FC_MAX = (DEATH_FRAMES > CLEAR_FRAMES) ? DEATH_FRAMES : CLEAR_FRAMES;
    localparam int FC_W   = $clog2(FC_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_DYING = 3'd2,
        S_CLEAR = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [19:0]       score_q, score_d;
    logic [2:0]        lives_q, lives_d;
    logic [3:0]        level_q, level_d;
    logic [7:0]        dots_q, dots_d;
    logic [FC_W-1:0]   fc_q, fc_d;
    logic              bonus_q, bonus_d;
    logic              start_q, start_d;
    logic              play_en_q, play_en_d;
    logic              respawn_q, respawn_d;
    logic              map_reload_q, map_reload_d;

    logic        eat, last_eat, die_done, clr_done, start_rise, gain_life;
    logic [19:0] bcd_sum, score_next;
    logic [4:0]  dig;
    logic [3:0]  add_v;
    logic        carry;

    assign eat        = (state_q == S_PLAY) && (ate_candy_stb || ate_power_cookie_stb) && (dots_q != 8'd0);
    assign last_eat   = eat && (dots_q == 8'd1);
    assign die_done   = frame_stb && (fc_q == FC_W'(DEATH_FRAMES - 1));
    assign clr_done   = frame_stb && (fc_q == FC_W'(CLEAR_FRAMES - 1));
    assign start_rise = start_btn && !start_q;

    // Points land in the tens digit; a carry out of the top digit means saturation.
    always_comb begin
        bcd_sum = score_q;
        carry   = 1'b0;
        dig     = 5'd0;
        add_v   = ate_power_cookie_stb ? 4'd5 : 4'd1;
        for (int i = 1; i < 5; i++) begin
            dig = {1'b0, score_q[i*4 +: 4]} + {1'b0, add_v} + {4'd0, carry};
            if (dig > 5'd9) begin
                dig   = dig - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            bcd_sum[i*4 +: 4] = dig[3:0];
            add_v = 4'd0;
        end
    end

    assign score_next = carry ? 20'h99990 : bcd_sum;
    assign gain_life  = !bonus_q && (score_q[19:16] == 4'd0) && (score_next[19:16] != 4'd0);

    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_btn) state_d = S_PLAY;
            S_PLAY: begin
                if (last_eat)         state_d = S_CLEAR;
                else if (pac_hit_stb) state_d = S_DYING;
            end
            S_DYING: if (die_done) state_d = (lives_q != 3'd0) ? S_PLAY : S_OVER;
            S_CLEAR: if (clr_done) state_d = S_PLAY;
            S_OVER:  if (start_rise) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        score_d      = score_q;
        lives_d      = lives_q;
        level_d      = level_q;
        dots_d       = dots_q;
        bonus_d      = bonus_q;
        start_d      = start_btn;
        respawn_d    = 1'b0;
        map_reload_d = 1'b0;
        play_en_d    = (state_d == S_PLAY);
        case (state_q)
            S_IDLE: if (state_d == S_PLAY) begin
                respawn_d    = 1'b1;
                map_reload_d = 1'b1;
                dots_d       = 8'(CANDY_TOTAL);
            end
            S_PLAY: begin
                if (eat) begin
                    score_d = score_next;
                    dots_d  = dots_q - 8'd1;
                    if (gain_life) begin
                        bonus_d = 1'b1;
                        lives_d = (lives_q == 3'd7) ? 3'd7 : lives_q + 3'd1;
                    end
                end
                if (state_d == S_DYING) lives_d = lives_d - 3'd1;
            end
            S_DYING: if (state_d == S_PLAY) respawn_d = 1'b1;
            S_CLEAR: if (clr_done) begin
                level_d      = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
                dots_d       = 8'(CANDY_TOTAL);
                respawn_d    = 1'b1;
                map_reload_d = 1'b1;
            end
            S_OVER: if (start_rise) begin
                score_d = 20'd0;
                lives_d = 3'(START_LIVES);
                level_d = 4'd1;
                bonus_d = 1'b0;
                dots_d  = 8'(CANDY_TOTAL);
            end
            default: ;
        endcase
        // Timer restarts on every state entry and only runs in the timed states.
        if (state_d != state_q)
            fc_d = '0;
        else if (frame_stb && (state_q == S_DYING || state_q == S_CLEAR))
            fc_d = fc_q + 1'b1;
        else
            fc_d = fc_q;
    end

    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q      <= 20'd0;
            lives_q      <= 3'(START_LIVES);
            level_q      <= 4'd1;
            dots_q       <= 8'(CANDY_TOTAL);
            fc_q         <= '0;
            bonus_q      <= 1'b0;
            start_q      <= 1'b0;
            play_en_q    <= 1'b0;
            respawn_q    <= 1'b0;
            map_reload_q <= 1'b0;
        end else begin
            score_q      <= score_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            dots_q       <= dots_d;
            fc_q         <= fc_d;
            bonus_q      <= bonus_d;
            start_q      <= start_d;
            play_en_q    <= play_en_d;
            respawn_q    <= respawn_d;
            map_reload_q <= map_reload_d;
        end
    end

    assign score_bcd      = score_q;
    assign lives          = lives_q;
    assign level          = level_q;
    assign dots_left      = dots_q;
    assign game_state     = state_q;
    assign play_en        = play_en_q;
    assign respawn_stb    = respawn_q;
    assign map_reload_stb = map_reload_q;
endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_score_keeper;
    localparam int CT = 244, SL = 3, DF = 120, CF = 180;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        frame_stb = 1'b0, start_btn = 1'b0, candy = 1'b0, power = 1'b0, hit = 1'b0;
    logic [19:0] score_bcd;
    logic [2:0]  lives, game_state;
    logic [3:0]  level;
    logic [7:0]  dots_left;
    logic        play_en, respawn_stb, map_reload_stb;

    score_keeper #(.CANDY_TOTAL(CT), .START_LIVES(SL), .DEATH_FRAMES(DF), .CLEAR_FRAMES(CF)) dut (
        .vga_pix_clk(clk), .rst_n(rst_n), .frame_stb(frame_stb), .start_btn(start_btn),
        .ate_candy_stb(candy), .ate_power_cookie_stb(power), .pac_hit_stb(hit),
        .score_bcd(score_bcd), .lives(lives), .level(level), .dots_left(dots_left),
        .game_state(game_state), .play_en(play_en), .respawn_stb(respawn_stb),
        .map_reload_stb(map_reload_stb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [19:0] score;
        logic [2:0]  lives;
        logic [3:0]  level;
        logic [7:0]  dots;
        logic        play, resp, map;
    } out_t;
    typedef struct { int due; out_t o; } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0, errors = 0;

    // Reference model: plain integers for score (decimal), lives, level, dots and phase.
    int m_st, m_score, m_lives, m_level, m_dots, m_fc, m_bonus, m_start_prev, m_resp, m_map;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] to_bcd(int v);
        logic [19:0] r;
        int t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic out_t model_out();
        out_t o;
        o.st = 3'(m_st); o.score = to_bcd(m_score); o.lives = 3'(m_lives);
        o.level = 4'(m_level); o.dots = 8'(m_dots); o.play = (m_st == 1);
        o.resp = m_resp[0]; o.map = m_map[0];
        return o;
    endfunction

    function automatic out_t act_out();
        out_t o;
        o.st = game_state; o.score = score_bcd; o.lives = lives; o.level = level;
        o.dots = dots_left; o.play = play_en; o.resp = respawn_stb; o.map = map_reload_stb;
        return o;
    endfunction

    task automatic check(input string nm, input out_t e);
        out_t a;
        a = act_out();
        vectors++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t state %0d/%0d score %h/%h lives %0d/%0d level %0d/%0d dots %0d/%0d play %b/%b resp %b/%b map %b/%b (actual/expected)",
                     nm, $time, a.st, e.st, a.score, e.score, a.lives, e.lives, a.level, e.level,
                     a.dots, e.dots, a.play, e.play, a.resp, e.resp, a.map, e.map);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check("cycle", e.o);
        end
    end

    task automatic model_reset();
        m_st = 0; m_score = 0; m_lives = SL; m_level = 1; m_dots = CT;
        m_fc = 0; m_bonus = 0; m_start_prev = 0; m_resp = 0; m_map = 0;
    endtask

    task automatic step(input logic c, input logic p, input logic h, input logic f, input logic s);
        int   ns, pts, nsc;
        exp_t e;
        @(posedge clk);
        #2;
        candy = c; power = p; hit = h; frame_stb = f; start_btn = s;
        ns = m_st; m_resp = 0; m_map = 0;
        case (m_st)
            0: if (s) begin ns = 1; m_resp = 1; m_map = 1; m_dots = CT; end
            1: begin
                if ((c || p) && m_dots > 0) begin
                    pts = p ? 50 : 10;
                    nsc = m_score + pts;
                    if (nsc > 99990) nsc = 99990;
                    if (!m_bonus && m_score < 10000 && nsc >= 10000) begin
                        m_bonus = 1;
                        if (m_lives < 7) m_lives++;
                    end
                    m_score = nsc;
                    m_dots--;
                    if (m_dots == 0) ns = 3;
                end
                if (ns == 1 && h) begin m_lives--; ns = 2; end
            end
            2: if (f) begin
                m_fc++;
                if (m_fc == DF) begin
                    if (m_lives > 0) begin ns = 1; m_resp = 1; end
                    else ns = 4;
                end
            end
            3: if (f) begin
                m_fc++;
                if (m_fc == CF) begin
                    ns = 1; m_dots = CT; m_resp = 1; m_map = 1;
                    if (m_level < 15) m_level++;
                end
            end
            4: if (s && !m_start_prev) begin
                ns = 0; m_score = 0; m_lives = SL; m_level = 1; m_bonus = 0; m_dots = CT;
            end
            default: ns = 0;
        endcase
        if (ns != m_st) m_fc = 0;
        m_start_prev = s;
        m_st = ns;
        e.due = cyc + 1;
        e.o = model_out();
        sb.push_back(e);
    endtask

    task automatic do_reset(input string nm);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        candy = 0; power = 0; hit = 0; frame_stb = 0; start_btn = 0;
        model_reset();
        #1;
        check(nm, model_out());
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t vectors %0d", $time, vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        do_reset("reset");
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        // Lose all lives; stray eat/hit strobes while dying must be ignored.
        for (int d = 0; d < SL; d++) begin
            step(0, 0, 1, 0, 0);
            for (int k = 0; k < DF; k++)
                step(k % 7 == 0, k % 11 == 0, k % 13 == 0, 1, 0);
            step(0, 0, 0, 0, 0);
        end
        step(1, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        // Eat through many levels to cross 10000 and hit the 99990 ceiling.
        for (int k = 0; k < 6000 && m_score < 99990; k++) begin
            if (m_st == 1 && m_dots == 1)  step(1, 0, 1, 0, 0);
            else if (m_st == 1)            step(1, $urandom_range(0, 7) != 0, 0, 0, 0);
            else                           step($urandom_range(0, 1), 0, $urandom_range(0, 1), 1, 0);
        end
        for (int k = 0; k < 300; k++)
            step(1, $urandom_range(0, 1), 0, 1, 0);
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 1), $urandom_range(0, 15) == 0);
        // Reset in the middle of a death sequence.
        do_reset("reset_idle");
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 1, 0);
        do_reset("reset_mid_dying");
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter CANDY_TOTAL, default 244, meaning pellets + power cookies per level.
REQ-002 SHALL have parameter START_LIVES, default 3, meaning lives at game start (1..7).
REQ-003 SHALL have parameter DEATH_FRAMES, default 120, meaning frames spent in DYING.
REQ-004 SHALL have parameter CLEAR_FRAMES, default 180, meaning frames spent in LEVEL_CLEAR.
REQ-005 SHALL have port vga_pix_clk  input  1  sole clock.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port frame_stb  input  1  one-cycle pulse per new frame.
REQ-008 SHALL have port start_btn  input  1  level-sensitive start request (OR of BTNU/D/L/R).
REQ-009 SHALL have port ate_candy_stb  input  1  one-cycle pulse, pellet eaten.
REQ-010 SHALL have port ate_power_cookie_stb  input  1  one-cycle pulse, power cookie eaten.
REQ-011 SHALL have port pac_hit_stb  input  1  one-cycle pulse, pacman touched an enemy.
REQ-012 SHALL have port score_bcd  output  20  five BCD digits, [3:0] = units.
REQ-013 SHALL have port lives  output  3  remaining lives.
REQ-014 SHALL have port level  output  4  current level, 1-based.
REQ-015 SHALL have port dots_left  output  8  edible tiles left this level.
REQ-016 SHALL have port game_state  output  3  encoded FSM state.
REQ-017 SHALL have port play_en  output  1  high only in PLAY; gates movement logic.
REQ-018 SHALL have port respawn_stb  output  1  one-cycle pulse, reposition actors.
REQ-019 SHALL have port map_reload_stb  output  1  one-cycle pulse, restore candy map.

Function
REQ-020 FSM states SHALL be IDLE=0, PLAY=1, DYING=2, LEVEL_CLEAR=3, GAME_OVER=4.
REQ-021 IDLE -> PLAY on start_btn high; SHALL assert map_reload_stb and respawn_stb in that same transition cycle.
REQ-022 PLAY -> DYING on pac_hit_stb; lives decremented by 1 in the same cycle.
REQ-023 PLAY -> LEVEL_CLEAR on the eat strobe that takes dots_left from 1 to 0.
REQ-024 DYING SHALL count DEATH_FRAMES frame_stb pulses, then -> PLAY with respawn_stb if lives>0, else -> GAME_OVER.
REQ-025 LEVEL_CLEAR SHALL count CLEAR_FRAMES frame_stb pulses, then -> PLAY; level increments (saturate 15), dots_left reloads CANDY_TOTAL, map_reload_stb and respawn_stb pulse.
REQ-026 GAME_OVER -> IDLE on a rising edge of start_btn (start_btn registered one cycle for edge detect); score, lives, level reset on that transition.
REQ-027 Eat and hit strobes SHALL be ignored outside PLAY.
REQ-028 Pellet SHALL add 10, power cookie 50: BCD add of 1 or 5 into tens digit with ripple carry, single cycle; units digit always 0.
REQ-029 Score SHALL saturate at 99990; no wrap.
REQ-030 Crossing 10000 (digit[16+] becomes nonzero first time) SHALL add one life once per game, lives saturate at 7.
REQ-031 Candy and power strobes in same cycle: power counted only (+50, dots_left -1).
REQ-032 Eat strobe and pac_hit_stb in same cycle: points counted; if dots_left reaches 0, LEVEL_CLEAR wins and hit ignored, else DYING.
REQ-033 dots_left SHALL never underflow; strobe at 0 is ignored.
REQ-034 All outputs SHALL be registered; response latency one vga_pix_clk after the input strobe.
REQ-035 Frame counter SHALL clear on every state entry; only frame_stb advances it.

Reset
REQ-036 rst_n low SHALL asynchronously force: game_state=IDLE, score_bcd=0, lives=START_LIVES, level=1, dots_left=CANDY_TOTAL, play_en=0, respawn_stb=0, map_reload_stb=0, frame counter=0, bonus-life flag=0.
REQ-037 Reset release mid-DYING or mid-LEVEL_CLEAR SHALL resume from IDLE with no residual strobe.

Verification
REQ-038 Reset, start_btn=1 one cycle -> next cycle game_state=1, play_en=1, respawn_stb=1, map_reload_stb=1 for exactly one cycle.
REQ-039 In PLAY, 3 candy + 1 power strobes -> score_bcd=0x00080, dots_left=240.
REQ-040 In PLAY with lives=1, pac_hit_stb -> lives=0, state=2; after 120 frame_stb -> state=4, no respawn_stb.
REQ-041 dots_left=1, ate_candy_stb with pac_hit_stb same cycle -> state=3, lives unchanged; after 180 frames level=2, dots_left=244, map_reload_stb pulse.
REQ-042 Score 09990 then candy -> score_bcd=0x10000, lives+1; later crossing unaffected; at 99990 further candy leaves 99990.
REQ-043 rst_n asserted mid-DYING -> immediately state=0, lives=3, score 0, all strobes 0.
